// File: rtl/vdp_reg_write_arbiter_pkg.sv
// Shared VDP definitions for the register-write arbiter.
// Holds the index and data widths, the grant encoding and the starvation-counter limits.
package vdp_reg_write_arbiter_pkg;

    localparam int VDP_ADDR_W = 5;
    localparam int VDP_DATA_W = 16;
    localparam int STARVE_W   = 6;
    localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

    typedef enum logic [1:0] {
        GRANT_IDLE   = 2'd0,
        GRANT_COPPER = 2'd1,
        GRANT_HOST   = 2'd2
    } grant_e;

    typedef struct packed {
        logic [VDP_ADDR_W-1:0] addr;
        logic [VDP_DATA_W-1:0] data;
    } reg_write_t;

    function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] value);
        return (value == STARVE_MAX) ? value : value + STARVE_W'(1);
    endfunction

endpackage

// File: rtl/vdp_reg_write_arbiter_fifo.sv
// Host write queue: power-of-two depth, wrapping pointers and an explicit level counter.
// Pushes while full and pops while empty are ignored, so the queue cannot be corrupted.
module vdp_reg_write_fifo
    import vdp_reg_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  reg_write_t       push_data_i,
    input  logic             pop_i,
    output reg_write_t       head_o,
    output logic [LVL_W-1:0] level_o
);

    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    reg_write_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && (level_q != DEPTH_L);
    assign do_pop  = pop_i && (level_q != '0);

    // Pointers wrap naturally at the power-of-two boundary; level never comes from pointer equality.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/vdp_reg_write_arbiter.sv
// Merges unstallable copper writes and queued host writes onto the single VDP register-file port.
// Copper always wins; a sticky flag records when the host has been locked out for 63 cycles.
module vdp_reg_write_arbiter
    import vdp_reg_write_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  host_write_en,
    input  logic [VDP_ADDR_W-1:0] host_address,
    input  logic [VDP_DATA_W-1:0] host_data,
    output logic                  host_ready,
    input  logic                  copper_write_en,
    input  logic [VDP_ADDR_W-1:0] copper_address,
    input  logic [VDP_DATA_W-1:0] copper_data,
    output logic                  reg_write_en,
    output logic [VDP_ADDR_W-1:0] reg_write_address,
    output logic [VDP_DATA_W-1:0] reg_write_data,
    output logic [4:0]            host_queue_level,
    output logic                  host_starved
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

    grant_e                state_q, state_d;
    logic [VDP_ADDR_W-1:0] addr_q, addr_d;
    logic [VDP_DATA_W-1:0] data_q, data_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic                  starved_q, starved_d;

    logic [LVL_W-1:0]      level;
    logic                  queue_nonempty;
    logic                  host_push;
    logic                  host_pop;
    reg_write_t            host_entry;
    reg_write_t            head;

    assign host_ready     = (level < DEPTH_L);
    assign queue_nonempty = (level != '0);
    assign host_push      = host_write_en && host_ready;
    assign host_pop       = (state_d == GRANT_HOST);
    assign host_entry     = '{addr: host_address, data: host_data};

    vdp_reg_write_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (host_push),
        .push_data_i (host_entry),
        .pop_i       (host_pop),
        .head_o      (head),
        .level_o     (level)
    );

    // The next state is the grant for this cycle; the registered state drives the write strobe.
    always_comb begin
        state_d   = GRANT_IDLE;
        addr_d    = addr_q;
        data_d    = data_q;
        starve_d  = '0;
        starved_d = starved_q;

        if (copper_write_en) begin
            state_d = GRANT_COPPER;
        end else if (queue_nonempty) begin
            state_d = GRANT_HOST;
        end

        case (state_d)
            GRANT_COPPER: begin
                addr_d = copper_address;
                data_d = copper_data;
            end
            GRANT_HOST: begin
                addr_d = head.addr;
                data_d = head.data;
            end
            default: begin
                addr_d = addr_q;
                data_d = data_q;
            end
        endcase

        if (state_d == GRANT_COPPER && queue_nonempty) begin
            starve_d = starve_inc(starve_q);
        end
        if (starve_d == STARVE_MAX) begin
            starved_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= GRANT_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            starve_q  <= '0;
            starved_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            starve_q  <= starve_d;
            starved_q <= starved_d;
        end
    end

    assign reg_write_en      = (state_q != GRANT_IDLE);
    assign reg_write_address = addr_q;
    assign reg_write_data    = data_q;
    assign host_queue_level  = 5'(level);
    assign host_starved      = starved_q;

endmodule

// File: tb/tb_vdp_reg_write_arbiter.sv
// Self-checking bench for vdp_reg_write_arbiter: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_vdp_reg_write_arbiter;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 63;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        host_write_en = 1'b0;
    logic [4:0]  host_address = '0;
    logic [15:0] host_data = '0;
    logic        host_ready;
    logic        copper_write_en = 1'b0;
    logic [4:0]  copper_address = '0;
    logic [15:0] copper_data = '0;
    logic        reg_write_en;
    logic [4:0]  reg_write_address;
    logic [15:0] reg_write_data;
    logic [4:0]  host_queue_level;
    logic        host_starved;

    always #5 clk = ~clk;

    vdp_reg_write_arbiter #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .host_write_en     (host_write_en),
        .host_address      (host_address),
        .host_data         (host_data),
        .host_ready        (host_ready),
        .copper_write_en   (copper_write_en),
        .copper_address    (copper_address),
        .copper_data       (copper_data),
        .reg_write_en      (reg_write_en),
        .reg_write_address (reg_write_address),
        .reg_write_data    (reg_write_data),
        .host_queue_level  (host_queue_level),
        .host_starved      (host_starved)
    );

    int          checks = 0;
    int          errors = 0;

    logic [20:0] modelQueue[$];
    logic        expEn = 1'b0;
    logic [4:0]  expAddr = '0;
    logic [15:0] expData = '0;
    logic        expStarved = 1'b0;
    int          blockedRun = 0;
    int          sizeBefore;
    logic [20:0] headEntry;

    int          idx;
    logic        wasReady;
    logic [4:0]  gotAddr[$];
    logic [15:0] gotData[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tickCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic cw, input logic [4:0] ca, input logic [15:0] cd,
                                 input logic hw, input logic [4:0] ha, input logic [15:0] hd);
        copper_write_en = cw;
        copper_address  = ca;
        copper_data     = cd;
        host_write_en   = hw;
        host_address    = ha;
        host_data       = hd;
        tickCycle();
    endtask

    // Reference model: a plain FIFO of pending host writes, copper-first priority,
    // and a count of consecutive cycles in which the host was blocked.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                modelQueue.delete();
                expEn      = 1'b0;
                expAddr    = '0;
                expData    = '0;
                expStarved = 1'b0;
                blockedRun = 0;
            end
            checkOutput("model_reg_write_en", 32'(reg_write_en), 32'(expEn));
            checkOutput("model_reg_write_address", 32'(reg_write_address), 32'(expAddr));
            checkOutput("model_reg_write_data", 32'(reg_write_data), 32'(expData));
            checkOutput("model_host_queue_level", 32'(host_queue_level), 32'(modelQueue.size()));
            checkOutput("model_host_ready", 32'(host_ready), 32'(modelQueue.size() < DEPTH));
            checkOutput("model_host_starved", 32'(host_starved), 32'(expStarved));
            if (reset_n) begin
                sizeBefore = modelQueue.size();
                if (copper_write_en) begin
                    expEn   = 1'b1;
                    expAddr = copper_address;
                    expData = copper_data;
                end else if (sizeBefore > 0) begin
                    headEntry = modelQueue.pop_front();
                    expEn     = 1'b1;
                    expAddr   = headEntry[20:16];
                    expData   = headEntry[15:0];
                end else begin
                    expEn = 1'b0;
                end
                if (host_write_en && sizeBefore < DEPTH) begin
                    modelQueue.push_back({host_address, host_data});
                end
                if (copper_write_en && sizeBefore > 0) begin
                    blockedRun = (blockedRun < STARVE_LIMIT) ? blockedRun + 1 : STARVE_LIMIT;
                end else begin
                    blockedRun = 0;
                end
                if (blockedRun >= STARVE_LIMIT) expStarved = 1'b1;
            end
        end
    end

    initial begin
        tickCycle();
        tickCycle();
        checkOutput("reset_host_ready", 32'(host_ready), 32'd1);
        checkOutput("reset_reg_write_en", 32'(reg_write_en), 32'd0);
        checkOutput("reset_level", 32'(host_queue_level), 32'd0);
        reset_n = 1'b1;

        // Two back-to-back host writes with the copper idle
        applyStimulus(1'b0, 5'd0, 16'h0000, 1'b1, 5'd3, 16'h1234);
        checkOutput("host_first_level", 32'(host_queue_level), 32'd1);
        checkOutput("host_first_no_write_yet", 32'(reg_write_en), 32'd0);
        applyStimulus(1'b0, 5'd0, 16'h0000, 1'b1, 5'd7, 16'hBEEF);
        checkOutput("host_a_en", 32'(reg_write_en), 32'd1);
        checkOutput("host_a_addr", 32'(reg_write_address), 32'd3);
        checkOutput("host_a_data", 32'(reg_write_data), 32'h1234);
        applyStimulus(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000);
        checkOutput("host_b_addr", 32'(reg_write_address), 32'd7);
        checkOutput("host_b_data", 32'(reg_write_data), 32'hBEEF);
        tickCycle();
        checkOutput("host_idle_en", 32'(reg_write_en), 32'd0);
        checkOutput("host_idle_hold_data", 32'(reg_write_data), 32'hBEEF);
        checkOutput("host_idle_level", 32'(host_queue_level), 32'd0);

        // Copper and host in the same cycle: copper first, host one cycle later
        applyStimulus(1'b1, 5'd1, 16'hAAAA, 1'b1, 5'd2, 16'h5555);
        checkOutput("collide_copper_addr", 32'(reg_write_address), 32'd1);
        checkOutput("collide_copper_data", 32'(reg_write_data), 32'hAAAA);
        checkOutput("collide_level", 32'(host_queue_level), 32'd1);
        applyStimulus(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000);
        checkOutput("collide_host_addr", 32'(reg_write_address), 32'd2);
        checkOutput("collide_host_data", 32'(reg_write_data), 32'h5555);

        // Five host writes under a busy copper: only four fit
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 5'd9, 16'h0900 + 16'(i), 1'b1, 5'd10 + 5'(i), 16'h1000 + 16'(i));
        end
        checkOutput("full_level", 32'(host_queue_level), 32'd4);
        checkOutput("full_ready_low", 32'(host_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000);
            checkOutput("full_drain_addr", 32'(reg_write_address), 32'd10 + 32'(i));
            checkOutput("full_drain_data", 32'(reg_write_data), 32'h1000 + 32'(i));
        end
        tickCycle();
        checkOutput("full_drained_level", 32'(host_queue_level), 32'd0);

        // Continuous copper traffic starving a single queued host write
        for (int i = 0; i < 70; i++) begin
            applyStimulus(1'b1, 5'd30, 16'h3000 + 16'(i), (i == 0), 5'd20, 16'hCAFE);
            if (i == 62) checkOutput("starve_not_yet", 32'(host_starved), 32'd0);
            if (i == 63) checkOutput("starve_set", 32'(host_starved), 32'd1);
        end
        applyStimulus(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000);
        checkOutput("starve_release_addr", 32'(reg_write_address), 32'd20);
        checkOutput("starve_release_data", 32'(reg_write_data), 32'hCAFE);
        checkOutput("starve_sticky", 32'(host_starved), 32'd1);

        // Reset in the middle of draining a three-deep queue
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'd30, 16'h2000, 1'b1, 5'd5 + 5'(i), 16'h5000 + 16'(i));
        end
        checkOutput("mid_level3", 32'(host_queue_level), 32'd3);
        applyStimulus(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_en", 32'(reg_write_en), 32'd0);
        checkOutput("rst_addr", 32'(reg_write_address), 32'd0);
        checkOutput("rst_data", 32'(reg_write_data), 32'd0);
        checkOutput("rst_level", 32'(host_queue_level), 32'd0);
        checkOutput("rst_ready", 32'(host_ready), 32'd1);
        checkOutput("rst_starved", 32'(host_starved), 32'd0);
        tickCycle();
        tickCycle();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tickCycle();
            checkOutput("post_rst_no_write", 32'(reg_write_en), 32'd0);
        end

        // Eight host writes through a full queue with simultaneous push and pop
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            wasReady = host_ready;
            applyStimulus(c < 4, 5'd31, 16'h7700, idx < 8, 5'(idx), 16'h4300 + 16'(idx));
            if (c == 4) checkOutput("wrap_full_ready", 32'(wasReady), 32'd0);
            if (idx < 8 && wasReady) idx++;
            if (c >= 4 && reg_write_en) begin
                gotAddr.push_back(reg_write_address);
                gotData.push_back(reg_write_data);
            end
        end
        checkOutput("wrap_count", 32'(gotAddr.size()), 32'd8);
        for (int i = 0; i < 8 && i < gotAddr.size(); i++) begin
            checkOutput("wrap_order_addr", 32'(gotAddr[i]), 32'(i));
            checkOutput("wrap_order_data", 32'(gotData[i]), 32'h4300 + 32'(i));
        end
        checkOutput("wrap_final_level", 32'(host_queue_level), 32'd0);

        tickCycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vdp_reg_write_arbiter.md
VDP_REG_WRITE_ARBITER -- requirements
Module: vdp_reg_write_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter FIFO_DEPTH, default 4, host write queue depth; legal values are powers of two from 2 to 16.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 host_write_en  input  1  host write request, qualified by host_ready.
REQ-006 host_address  input  5  host target register index.
REQ-007 host_data  input  16  host write data.
REQ-008 host_ready  output  1  queue can accept a host write this cycle.
REQ-009 copper_write_en  input  1  copper register write strobe; the copper cannot be stalled.
REQ-010 copper_address  input  5  copper target register index.
REQ-011 copper_data  input  16  copper write data.
REQ-012 reg_write_en  output  1  single VDP register-file write strobe.
REQ-013 reg_write_address  output  5  register-file write index.
REQ-014 reg_write_data  output  16  register-file write data.
REQ-015 host_queue_level  output  5  number of queued host writes (0..FIFO_DEPTH).
REQ-016 host_starved  output  1  sticky flag; clears on reset only.

Function
REQ-017 A host write SHALL be accepted on a rising edge where host_write_en=1 and host_ready=1; a request while host_ready=0 SHALL be ignored and SHALL NOT corrupt the queue.
REQ-018 host_ready SHALL be 1 exactly when host_queue_level < FIFO_DEPTH, derived from registered state only.
REQ-019 Grant rules each cycle: copper_write_en=1 grants COPPER; else queue non-empty grants HOST; else IDLE.
REQ-020 Output latency SHALL be exactly one cycle: a grant in cycle N drives reg_write_en/address/data in cycle N+1.
REQ-021 On a COPPER grant, outputs SHALL carry copper_address/copper_data; on a HOST grant, the queue head, which SHALL then be popped.
REQ-022 On IDLE, reg_write_en SHALL be 0 and address/data SHALL hold their previous values.
REQ-023 A push and a pop in the same cycle SHALL leave host_queue_level unchanged and preserve FIFO order.
REQ-024 Queue read/write pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; level SHALL be tracked separately, never inferred from pointer equality.
REQ-025 Host writes SHALL reach the register file in acceptance order.
REQ-026 No copper write SHALL ever be dropped or delayed beyond the one-cycle latency.
REQ-027 Same-address copper and host writes SHALL be applied in grant order, with no merging.
REQ-028 A 6-bit starvation counter SHALL increment each cycle the queue is non-empty and copper wins, and reset to 0 on any HOST grant or empty queue.
REQ-029 The counter SHALL saturate at 63, and host_starved SHALL set when it reaches 63.
REQ-030 FSM states: IDLE, COPPER, HOST, recording the last grant; transitions follow REQ-019 every cycle with no dwell.

Reset
REQ-031 Asserting reset_n low SHALL immediately clear: queue level and pointers, starvation counter, host_starved, reg_write_en, reg_write_address, reg_write_data, and the FSM (to IDLE).
REQ-032 Queued writes SHALL be discarded on reset, including reset mid-drain; no partial write SHALL appear after release.
REQ-033 host_ready SHALL read 1 during and after reset.
REQ-034 Queue storage contents need not be reset.

Structure
REQ-035 The shared VDP package SHALL hold the register-index width (5), the data width (16) and the grant-state encoding.
REQ-036 The queue SHALL be a single sub-module, vdp_reg_write_fifo: parameterised depth, push/pop, level output.
REQ-037 Arbitration, output registers and starvation logic SHALL live in the top module.

Verification
REQ-038 Idle copper; host writes (3,0x1234) then (7,0xBEEF) on consecutive cycles -> reg_write_en pulses one cycle later each, in order; level returns to 0.
REQ-039 Copper writes (1,0xAAAA) at the same cycle a host write (2,0x5555) is accepted -> cycle N+1 drives (1,0xAAAA); host write appears at N+2.
REQ-040 Copper busy; 5 host writes attempted -> 4 accepted, host_ready=0 at level 4, 5th ignored; after copper stops, 4 writes drain in order.
REQ-041 Copper continuous 70 cycles with 1 host write queued -> host_starved=1 at the 63rd blocked cycle; host write emitted on the first free cycle.
REQ-042 Queue level 3, reset_n pulsed low mid-drain -> outputs 0 immediately; no queued write appears after release; level=0; host_ready=1.
REQ-043 Full queue, simultaneous pop and new push after pop frees space -> pointers wrap past index 3 and order is preserved across 8 writes.
